// File: rtl/capture_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// capture_buffer_ctrl
//
// Sample-capture controller with an internal inferred dual-port RAM. It sits
// between a streaming DSP source and a debug/readout consumer.
//
// Two capture modes, selected when the controller is armed:
//   mode 0 : post-trigger one-shot. Nothing is stored until a trigger edge;
//            the trigger sample and the next DEPTH-1 samples are kept.
//   mode 1 : circular pre-trigger. PRE_TRIG samples are filled first, then the
//            buffer keeps overwriting until a trigger edge. The final capture
//            holds PRE_TRIG samples before the trigger and DEPTH-PRE_TRIG from
//            the trigger on.
// The finished capture is drained oldest-first over a valid/ready stream.
//
// Ports
//   clock         in   rising-edge clock
//   i_reset       in   asynchronous active-high reset
//   i_data        in   sample input                      [NB_DATA]
//   i_data_valid  in   sample strobe
//   i_trigger     in   trigger level (edge sampled on valid cycles)
//   i_mode        in   capture mode, sampled with i_arm
//   i_arm         in   start request, honoured in IDLE
//   i_abort       in   synchronous return to IDLE from any state
//   i_rd_start    in   start readout, honoured in DONE
//   i_rd_ready    in   consumer ready
//   o_rd_data     out  readout sample                    [NB_DATA]
//   o_rd_valid    out  readout sample valid
//   o_rd_last     out  final word of the readout
//   o_trig_addr   out  RAM address of the trigger sample [NB_ADDR]
//   o_state       out  IDLE=0 FILL=1 WAIT_TRIG=2 POST=3 DONE=4 READ=5
//   o_done        out  capture complete (memory full)
// -----------------------------------------------------------------------------
module capture_buffer_ctrl #(
    parameter int NB_DATA  = 14,
    parameter int NB_ADDR  = 11,
    parameter int PRE_TRIG = 256
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_data_valid,
    input  logic               i_trigger,
    input  logic               i_mode,
    input  logic               i_arm,
    input  logic               i_abort,
    input  logic               i_rd_start,
    input  logic               i_rd_ready,
    output logic [NB_DATA-1:0] o_rd_data,
    output logic               o_rd_valid,
    output logic               o_rd_last,
    output logic [NB_ADDR-1:0] o_trig_addr,
    output logic [2:0]         o_state,
    output logic               o_done
);

    localparam int               DEPTH      = 2**NB_ADDR;
    localparam logic [NB_ADDR:0] C_ONE      = (NB_ADDR+1)'(1);
    localparam logic [NB_ADDR:0] C_DEPTH    = (NB_ADDR+1)'(DEPTH);
    localparam logic [NB_ADDR:0] C_PRE      = (NB_ADDR+1)'(PRE_TRIG);
    localparam logic [NB_ADDR:0] C_POST_M1  = C_DEPTH - C_PRE;
    localparam logic [NB_ADDR:0] C_LAST_IDX = C_DEPTH - C_ONE;
    localparam logic             C_HAS_PRE  = (PRE_TRIG != 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4,
        ST_READ      = 3'd5
    } state_t;

    // ---------------------------------------------------------------- storage
    logic [NB_DATA-1:0] r_mem [DEPTH];
    logic [NB_DATA-1:0] r_ram_q;

    // ------------------------------------------------------------- registers
    state_t             r_state;
    logic               r_mode;
    logic               r_trig_d;
    logic [NB_ADDR-1:0] r_wr_ptr;
    logic [NB_ADDR:0]   r_pre_cnt;
    logic [NB_ADDR:0]   r_post_cnt;
    logic [NB_ADDR-1:0] r_trig_addr;
    logic [NB_ADDR-1:0] r_rd_ptr;
    logic [NB_ADDR:0]   r_iss_cnt;
    logic [NB_ADDR:0]   r_rd_cnt;
    logic               r_q_vld;
    logic [NB_DATA-1:0] r_rd_data;
    logic               r_rd_valid;
    logic               r_rd_last;
    logic               r_done;

    // ----------------------------------------------------------------- wires
    state_t             w_state_nxt;
    logic               w_trig_ev;
    logic [NB_ADDR:0]   w_post_tgt;
    logic               w_wr_en;
    logic               w_arm_go;
    logic               w_trig_hit;
    logic               w_rd_go;
    logic               w_pre_inc;
    logic               w_post_inc;
    logic               w_hs;
    logic               w_load;
    logic               w_issue;

    // A level that is already high never fires: only a low-to-high change
    // between two valid samples counts as a trigger event.
    assign w_trig_ev  = i_data_valid & i_trigger & ~r_trig_d;
    assign w_post_tgt = r_mode ? C_POST_M1 : C_DEPTH;

    // Readout pipeline: RAM read register (r_ram_q/r_q_vld) feeds the output
    // register. The output loads whenever it is empty or being consumed, and
    // a new RAM read is issued only if the RAM register will be free, so data
    // never gets overwritten during a stall and streaming runs at 1 word/cycle.
    assign w_hs    = r_rd_valid & i_rd_ready;
    assign w_load  = r_q_vld & (~r_rd_valid | i_rd_ready) & ~i_abort;
    assign w_issue = (r_state == ST_READ) & ~i_abort &
                     (r_iss_cnt != C_DEPTH) & (~r_q_vld | w_load);

    // FSM state register.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and per-cycle control strobes; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_arm_go    = 1'b0;
        w_trig_hit  = 1'b0;
        w_rd_go     = 1'b0;
        w_pre_inc   = 1'b0;
        w_post_inc  = 1'b0;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_arm) begin
                        w_arm_go = 1'b1;
                        if (i_mode && C_HAS_PRE) begin
                            w_state_nxt = ST_FILL;
                        end else begin
                            w_state_nxt = ST_WAIT_TRIG;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    // Trigger edges are deliberately ignored until the
                    // pre-trigger history is complete.
                    if (i_data_valid) begin
                        w_wr_en   = 1'b1;
                        w_pre_inc = 1'b1;
                        if ((r_pre_cnt + C_ONE) == C_PRE) begin
                            w_state_nxt = ST_WAIT_TRIG;
                        end else begin
                            w_state_nxt = ST_FILL;
                        end
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (w_trig_ev) begin
                        // The trigger sample itself is the first post sample.
                        w_wr_en    = 1'b1;
                        w_trig_hit = 1'b1;
                        if (w_post_tgt == C_ONE) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_POST;
                        end
                    end else if (i_data_valid && r_mode) begin
                        w_wr_en = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_TRIG;
                    end
                end
                ST_POST: begin
                    if (i_data_valid) begin
                        w_wr_en    = 1'b1;
                        w_post_inc = 1'b1;
                        if ((r_post_cnt + C_ONE) == w_post_tgt) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_POST;
                        end
                    end else begin
                        w_state_nxt = ST_POST;
                    end
                end
                ST_DONE: begin
                    if (i_rd_start) begin
                        w_rd_go     = 1'b1;
                        w_state_nxt = ST_READ;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_READ: begin
                    if (w_hs && r_rd_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Trigger history: follows the trigger level on valid samples only.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_trig_d <= 1'b0;
        end else if (i_data_valid) begin
            r_trig_d <= i_trigger;
        end
    end

    // Capture-side bookkeeping: mode latch, write pointer, fill/post counters
    // and the trigger address (kept across abort).
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_mode      <= 1'b0;
            r_wr_ptr    <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_trig_addr <= '0;
        end else begin
            if (w_arm_go) begin
                r_mode     <= i_mode;
                r_wr_ptr   <= '0;
                r_pre_cnt  <= '0;
                r_post_cnt <= '0;
            end else if (w_wr_en) begin
                // Natural wrap of the NB_ADDR-bit pointer gives modulo DEPTH.
                r_wr_ptr <= r_wr_ptr + NB_ADDR'(1);
            end
            if (w_pre_inc) begin
                r_pre_cnt <= r_pre_cnt + C_ONE;
            end
            if (w_trig_hit) begin
                r_trig_addr <= r_wr_ptr;
                r_post_cnt  <= C_ONE;
            end else if (w_post_inc) begin
                r_post_cnt <= r_post_cnt + C_ONE;
            end
        end
    end

    // RAM write port and registered read port (no reset: pure storage).
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
        if (w_issue) begin
            r_ram_q <= r_mem[r_rd_ptr];
        end
    end

    // Readout address/issue tracking; the read starts at the oldest sample,
    // which is where the write pointer rests once the capture is complete.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_ptr  <= '0;
            r_iss_cnt <= '0;
            r_q_vld   <= 1'b0;
        end else begin
            if (w_rd_go) begin
                r_rd_ptr  <= r_wr_ptr;
                r_iss_cnt <= '0;
            end else if (w_issue) begin
                r_rd_ptr  <= r_rd_ptr + NB_ADDR'(1);
                r_iss_cnt <= r_iss_cnt + C_ONE;
            end
            if (i_abort) begin
                r_q_vld <= 1'b0;
            end else if (w_issue) begin
                r_q_vld <= 1'b1;
            end else if (w_load) begin
                r_q_vld <= 1'b0;
            end
        end
    end

    // Output stage: holds while stalled, loads the prefetched word otherwise.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_cnt   <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_rd_go) begin
                r_rd_cnt <= '0;
            end else if (w_load) begin
                r_rd_cnt <= r_rd_cnt + C_ONE;
            end
            if (i_abort) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end else if (w_load) begin
                r_rd_data  <= r_ram_q;
                r_rd_valid <= 1'b1;
                r_rd_last  <= (r_rd_cnt == C_LAST_IDX);
            end else if (w_hs) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_last   = r_rd_last;
    assign o_trig_addr = r_trig_addr;
    assign o_state     = r_state;
    assign o_done      = r_done;

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for capture_buffer_ctrl (NB_DATA=8, NB_ADDR=4, PRE_TRIG=4).
// Each capture is described by a plan of (data, trigger) samples. A reference
// model works out from the plan where the trigger event falls and which
// DEPTH samples must come back, pushing them into a scoreboard queue. A
// separate monitor pops and compares on every readout handshake.
// -----------------------------------------------------------------------------
module tb_capture_buffer_ctrl;

    localparam int NB_DATA  = 8;
    localparam int NB_ADDR  = 4;
    localparam int PRE_TRIG = 4;
    localparam int DEPTH    = 16;
    localparam int PLAN_LEN = 64;

    logic               clock = 1'b0;
    logic               i_reset;
    logic [NB_DATA-1:0] i_data;
    logic               i_data_valid;
    logic               i_trigger;
    logic               i_mode;
    logic               i_arm;
    logic               i_abort;
    logic               i_rd_start;
    logic               i_rd_ready;
    logic [NB_DATA-1:0] o_rd_data;
    logic               o_rd_valid;
    logic               o_rd_last;
    logic [NB_ADDR-1:0] o_trig_addr;
    logic [2:0]         o_state;
    logic               o_done;

    capture_buffer_ctrl #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR),
        .PRE_TRIG(PRE_TRIG)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_data      (i_data),
        .i_data_valid(i_data_valid),
        .i_trigger   (i_trigger),
        .i_mode      (i_mode),
        .i_arm       (i_arm),
        .i_abort     (i_abort),
        .i_rd_start  (i_rd_start),
        .i_rd_ready  (i_rd_ready),
        .o_rd_data   (o_rd_data),
        .o_rd_valid  (o_rd_valid),
        .o_rd_last   (o_rd_last),
        .o_trig_addr (o_trig_addr),
        .o_state     (o_state),
        .o_done      (o_done)
    );

    always #5 clock = ~clock;

    int           n_pass  = 0;
    int           n_total = 0;
    logic [8:0]   sb[$];          // {last, data}
    int           hs_cnt;
    bit           mon_en;
    bit           prev_stall;
    logic [7:0]   prev_data;
    logic         prev_last;
    logic [7:0]   plan_d[PLAN_LEN];
    bit           plan_t[PLAN_LEN];
    bit           tb_trig_d;      // trigger level of the last valid sample

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: scoreboard pop on handshake, stability check while stalled.
    always @(negedge clock) begin
        logic [8:0] e;
        if (mon_en && !i_reset) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(o_rd_valid), 32'd1);
                chk("hold_data", 32'(o_rd_data), 32'(prev_data));
                chk("hold_last", 32'(o_rd_last), 32'(prev_last));
            end
            if (o_rd_valid && i_rd_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: got word %0d expected none", o_rd_data);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", 32'(o_rd_data), 32'(e[7:0]));
                    chk("rd_last", 32'(o_rd_last), 32'(e[8]));
                end
            end
            prev_stall = o_rd_valid & ~i_rd_ready;
            prev_data  = o_rd_data;
            prev_last  = o_rd_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push(input logic [7:0] d, input bit t, input bit glitch_arm, input bit gap);
        if (gap) begin
            i_data_valid = 1'b0;
            i_trigger    = 1'($urandom_range(0, 1));
            step();
        end
        i_data       = d;
        i_trigger    = t;
        i_data_valid = 1'b1;
        i_arm        = glitch_arm;
        step();
        i_data_valid = 1'b0;
        i_arm        = 1'b0;
        tb_trig_d    = t;
    endtask

    task automatic rand_plan();
        for (int i = 0; i < PLAN_LEN; i++) begin
            plan_d[i] = 8'($urandom);
            plan_t[i] = ($urandom_range(0, 3) == 0);
        end
        plan_t[40] = 1'b0;
        plan_t[41] = 1'b1;
    endtask

    // Arm, feed exactly the samples the model says are needed, check the
    // finished capture and enqueue the expected readout.
    task automatic run_capture(input bit mode, input int chk_idx, input int glitch_idx, input bit gaps);
        int k;
        int need;
        int first;
        bit p;
        i_mode       = mode;
        i_arm        = 1'b1;
        i_data_valid = 1'b0;
        step();
        i_arm = 1'b0;
        k = -1;
        for (int i = 0; i < PLAN_LEN; i++) begin
            p = (i == 0) ? tb_trig_d : plan_t[i-1];
            if (k < 0 && i >= (mode ? PRE_TRIG : 0) && plan_t[i] && !p) k = i;
        end
        if (k < 0) begin
            n_total++;
            $display("FAIL plan_event: got none expected one");
            return;
        end
        need = k + (mode ? DEPTH - PRE_TRIG : DEPTH);
        for (int i = 0; i < need; i++) begin
            if (i == chk_idx) chk("wait_state", 32'(o_state), 32'd2);
            if (i == need - 1) chk("post_state", 32'(o_state), 32'd3);
            push(plan_d[i], plan_t[i], (i == glitch_idx), gaps && ($urandom_range(0, 3) == 0));
        end
        chk("done_state", 32'(o_state), 32'd4);
        chk("done_flag", 32'(o_done), 32'd1);
        chk("trig_addr", 32'(o_trig_addr), mode ? 32'(k % DEPTH) : 32'd0);
        first = mode ? k - PRE_TRIG : k;
        for (int j = 0; j < DEPTH; j++) sb.push_back({(j == DEPTH - 1), plan_d[first + j]});
    endtask

    function automatic logic rdy(input int rmode, input int c);
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic readout(input int rmode);
        int c;
        hs_cnt     = 0;
        c          = 0;
        i_rd_ready = rdy(rmode, c);
        i_rd_start = 1'b1;
        step();
        i_rd_start = 1'b0;
        chk("lat0", 32'(o_rd_valid), 32'd0);
        c++; i_rd_ready = rdy(rmode, c);
        step();
        chk("lat1", 32'(o_rd_valid), 32'd0);
        c++; i_rd_ready = rdy(rmode, c);
        step();
        chk("lat2", 32'(o_rd_valid), 32'd1);
        while (o_state != 3'd0 && c < 300) begin
            c++; i_rd_ready = rdy(rmode, c);
            step();
        end
        i_rd_ready = 1'b0;
        chk("rd_idle", 32'(o_state), 32'd0);
        chk("hs_count", 32'(hs_cnt), 32'd16);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("rv_low", 32'(o_rd_valid), 32'd0);
        chk("done_low", 32'(o_done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        i_reset = 1'b1; i_data = '0; i_data_valid = 1'b0; i_trigger = 1'b0;
        i_mode = 1'b0; i_arm = 1'b0; i_abort = 1'b0; i_rd_start = 1'b0;
        i_rd_ready = 1'b0; tb_trig_d = 1'b0; mon_en = 1'b1; prev_stall = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        i_reset = 1'b0;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_valid", 32'(o_rd_valid), 32'd0);
        chk("rst_last", 32'(o_rd_last), 32'd0);
        chk("rst_data", 32'(o_rd_data), 32'd0);
        chk("rst_taddr", 32'(o_trig_addr), 32'd0);

        // Mode 0 ramp, trigger rises on sample 20.
        for (int i = 0; i < PLAN_LEN; i++) begin plan_d[i] = 8'(i); plan_t[i] = (i >= 20); end
        run_capture(1'b0, -1, -1, 1'b0);
        readout(0);

        // Mode 1 ramp, trigger on sample 30, stray arm mid-capture ignored.
        for (int i = 0; i < PLAN_LEN; i++) begin plan_d[i] = 8'(i); plan_t[i] = (i >= 30); end
        run_capture(1'b1, -1, 10, 1'b0);
        readout(1);

        // Mode 1, trigger raised during FILL and held: no capture until re-raised.
        for (int i = 0; i < PLAN_LEN; i++) begin plan_d[i] = 8'(i); plan_t[i] = (i >= 2) && (i != 30); end
        run_capture(1'b1, 30, -1, 1'b0);
        readout(2);

        // Abort in POST, rd_start in IDLE, arm+abort together, then re-arm.
        for (int i = 0; i < PLAN_LEN; i++) begin plan_d[i] = 8'(100 + i); plan_t[i] = (i == 9); end
        i_mode = 1'b1; i_arm = 1'b1;
        step();
        i_arm = 1'b0;
        for (int i = 0; i < 13; i++) push(plan_d[i], plan_t[i], 1'b0, 1'b0);
        chk("abort_pre_state", 32'(o_state), 32'd3);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("abort_state", 32'(o_state), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_taddr", 32'(o_trig_addr), 32'd9);
        i_rd_start = 1'b1;
        step();
        i_rd_start = 1'b0;
        chk("rdstart_idle", 32'(o_state), 32'd0);
        step(); step();
        chk("rdstart_novalid", 32'(o_rd_valid), 32'd0);
        i_arm = 1'b1; i_abort = 1'b1;
        step();
        i_arm = 1'b0; i_abort = 1'b0;
        chk("arm_abort_state", 32'(o_state), 32'd0);
        rand_plan();
        run_capture(1'b1, -1, -1, 1'b0);
        readout(0);

        // Randomized captures with valid gaps and random backpressure.
        for (int n = 0; n < 6; n++) begin
            rand_plan();
            run_capture(1'($urandom_range(0, 1)), -1, -1, 1'b1);
            readout(int'($urandom_range(0, 2)));
        end

        // Asynchronous reset in the middle of a readout.
        rand_plan();
        run_capture(1'b0, -1, -1, 1'b0);
        hs_cnt = 0;
        i_rd_ready = 1'b1;
        i_rd_start = 1'b1;
        step();
        i_rd_start = 1'b0;
        c = 0;
        while (hs_cnt < 5 && c < 50) begin c++; step(); end
        chk("pre_reset_state", 32'(o_state), 32'd5);
        chk("pre_reset_valid", 32'(o_rd_valid), 32'd1);
        mon_en = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        chk("areset_valid", 32'(o_rd_valid), 32'd0);
        chk("areset_state", 32'(o_state), 32'd0);
        chk("areset_taddr", 32'(o_trig_addr), 32'd0);
        chk("areset_last", 32'(o_rd_last), 32'd0);
        i_reset = 1'b0;
        i_rd_ready = 1'b0;
        sb.delete();
        tb_trig_d = 1'b0;
        prev_stall = 1'b0;
        mon_en = 1'b1;

        // Recovery after reset.
        rand_plan();
        run_capture(1'b1, -1, -1, 1'b1);
        readout(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
